// File: rtl/systolic_matmul_engine.sv
// Output-stationary M x P systolic matmul (C = A x B) with runtime K, input skew and valid/ready streaming.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; default build is unsigned.
module systolic_matmul_engine #(
    parameter int M        = 4,
    parameter int P        = 4,
    parameter int BITWIDTH = 8,
    parameter int KMAX     = 256,
    parameter int ACCW     = 2*BITWIDTH + $clog2(KMAX)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(KMAX+1)-1:0]  k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [M*BITWIDTH-1:0]      a_col,
    input  logic [P*BITWIDTH-1:0]      b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [P*ACCW-1:0]          out_data,
    output logic [$clog2(M)-1:0]       out_row,
    output logic                       busy,
    output logic                       done
);
    localparam int KW = $clog2(KMAX+1);
    localparam int FW = $clog2(M+P);
    localparam int RW = $clog2(M) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t          r_state, w_next;
    logic [KW-1:0]   r_klen, r_beats;
    logic [FW-1:0]   r_fcnt;
    logic [RW-1:0]   r_row;
    logic            w_beat, w_adv, w_clr;

    logic [BITWIDTH-1:0] r_a_sk  [M][M];
    logic [BITWIDTH-1:0] r_b_sk  [P][P];
    logic [BITWIDTH-1:0] w_a_new [M];
    logic [BITWIDTH-1:0] w_b_new [P];
    logic [BITWIDTH-1:0] w_a_skw [M];
    logic [BITWIDTH-1:0] w_b_skw [P];
    logic [BITWIDTH-1:0] w_a_pe  [M][P];
    logic [BITWIDTH-1:0] w_b_pe  [M][P];
    logic [BITWIDTH-1:0] r_a_fwd [M][P-1];
    logic [BITWIDTH-1:0] r_b_fwd [M-1][P];
    logic [ACCW-1:0]     r_acc   [M][P];
    logic [ACCW-1:0]     w_prod  [M][P];

    assign w_beat = in_valid && (r_state == S_LOAD);
    assign w_adv  = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign w_clr  = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = (k_len == '0) ? S_DRAIN : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_beat && (r_beats == r_klen - KW'(1))) w_next = S_FLUSH;
            end
            S_FLUSH: if (r_fcnt == FW'(M+P-2)) w_next = S_DRAIN;
            S_DRAIN: begin
                // Row index M is a one-cycle terminal slot that carries the done pulse.
                if (r_row == RW'(M)) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    out_valid = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_klen  <= '0;
            r_beats <= '0;
            r_fcnt  <= '0;
            r_row   <= '0;
        end else begin
            if (w_clr) begin
                r_klen  <= k_len;
                r_beats <= '0;
                r_fcnt  <= '0;
                r_row   <= '0;
            end
            if (w_beat)                 r_beats <= r_beats + 1'b1;
            if (r_state == S_FLUSH)     r_fcnt  <= r_fcnt + 1'b1;
            if (out_valid && out_ready) r_row   <= r_row + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < M; i++) w_a_new[i] = w_beat ? a_col[i*BITWIDTH +: BITWIDTH] : '0;
        for (int j = 0; j < P; j++) w_b_new[j] = w_beat ? b_row[j*BITWIDTH +: BITWIDTH] : '0;
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_askw
        if (gi == 0) begin : g_d0
            assign w_a_skw[gi] = w_a_new[gi];
        end else begin : g_dn
            assign w_a_skw[gi] = r_a_sk[gi][gi-1];
        end
    end

    for (genvar gj = 0; gj < P; gj++) begin : g_bskw
        if (gj == 0) begin : g_d0
            assign w_b_skw[gj] = w_b_new[gj];
        end else begin : g_dn
            assign w_b_skw[gj] = r_b_sk[gj][gj-1];
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < P; gj++) begin : g_col
            logic [2*BITWIDTH-1:0] w_p;
            if (gj == 0) begin : g_ain
                assign w_a_pe[gi][gj] = w_a_skw[gi];
            end else begin : g_afw
                assign w_a_pe[gi][gj] = r_a_fwd[gi][gj-1];
            end
            if (gi == 0) begin : g_bin
                assign w_b_pe[gi][gj] = w_b_skw[gj];
            end else begin : g_bfw
                assign w_b_pe[gi][gj] = r_b_fwd[gi-1][gj];
            end
`ifdef SYSTOLIC_SIGNED_EN
            assign w_p = {{BITWIDTH{w_a_pe[gi][gj][BITWIDTH-1]}}, w_a_pe[gi][gj]}
                       * {{BITWIDTH{w_b_pe[gi][gj][BITWIDTH-1]}}, w_b_pe[gi][gj]};
            assign w_prod[gi][gj] = {{(ACCW-2*BITWIDTH){w_p[2*BITWIDTH-1]}}, w_p};
`else
            assign w_p = {{BITWIDTH{1'b0}}, w_a_pe[gi][gj]} * {{BITWIDTH{1'b0}}, w_b_pe[gi][gj]};
            assign w_prod[gi][gj] = {{(ACCW-2*BITWIDTH){1'b0}}, w_p};
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++) for (int d = 0; d < M; d++) r_a_sk[i][d] <= '0;
            for (int j = 0; j < P; j++) for (int d = 0; d < P; d++) r_b_sk[j][d] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < P-1; j++) r_a_fwd[i][j] <= '0;
            for (int i = 0; i < M-1; i++) for (int j = 0; j < P; j++) r_b_fwd[i][j] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < P; j++) r_acc[i][j] <= '0;
        end else if (w_clr) begin
            for (int i = 0; i < M; i++) for (int d = 0; d < M; d++) r_a_sk[i][d] <= '0;
            for (int j = 0; j < P; j++) for (int d = 0; d < P; d++) r_b_sk[j][d] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < P-1; j++) r_a_fwd[i][j] <= '0;
            for (int i = 0; i < M-1; i++) for (int j = 0; j < P; j++) r_b_fwd[i][j] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < P; j++) r_acc[i][j] <= '0;
        end else if (w_adv) begin
            // Idle LOAD cycles shift zeros in, so bubbles add nothing to the sums.
            for (int i = 0; i < M; i++) begin
                r_a_sk[i][0] <= w_a_new[i];
                for (int d = 1; d < M; d++) r_a_sk[i][d] <= r_a_sk[i][d-1];
            end
            for (int j = 0; j < P; j++) begin
                r_b_sk[j][0] <= w_b_new[j];
                for (int d = 1; d < P; d++) r_b_sk[j][d] <= r_b_sk[j][d-1];
            end
            for (int i = 0; i < M; i++) for (int j = 0; j < P-1; j++) r_a_fwd[i][j] <= w_a_pe[i][j];
            for (int i = 0; i < M-1; i++) for (int j = 0; j < P; j++) r_b_fwd[i][j] <= w_b_pe[i][j];
            for (int i = 0; i < M; i++) for (int j = 0; j < P; j++) r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
        end
    end

    assign out_row = r_row[RW-2:0];

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < P; j++) out_data[j*ACCW +: ACCW] = r_acc[r_row[RW-2:0]][j];
        end
    end
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Randomized bench for systolic_matmul_engine, checked against a plain-arithmetic matrix-product model.
module tb_systolic_matmul_engine;
    localparam int M    = 4;
    localparam int P    = 4;
    localparam int BW   = 8;
    localparam int KMAX = 256;
    localparam int ACCW = 2*BW + $clog2(KMAX);
    localparam int KW   = $clog2(KMAX+1);
    localparam longint MASK = (longint'(1) << ACCW) - 1;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [M*BW-1:0]      a_col;
    logic [P*BW-1:0]      b_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [P*ACCW-1:0]    out_data;
    logic [$clog2(M)-1:0] out_row;
    logic                 busy;
    logic                 done;

    systolic_matmul_engine #(.M(M), .P(P), .BITWIDTH(BW), .KMAX(KMAX), .ACCW(ACCW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [BW-1:0] ma [M][KMAX];
    logic [BW-1:0] mb [KMAX][P];
    longint        exp_c [M][P];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    function automatic longint prodv(input logic [BW-1:0] a, input logic [BW-1:0] b);
`ifdef SYSTOLIC_SIGNED_EN
        return longint'($signed(a)) * longint'($signed(b));
`else
        return longint'(a) * longint'(b);
`endif
    endfunction

    task automatic compute_exp(input int k);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < P; j++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++) s += prodv(ma[i][kk], mb[kk][j]);
                exp_c[i][j] = s & MASK;
            end
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < M; i++) ma[i][kk] = BW'($urandom);
            for (int j = 0; j < P; j++) mb[kk][j] = BW'($urandom);
        end
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < M; i++) a_col[i*BW +: BW] = ma[i][kk];
        for (int j = 0; j < P; j++) b_row[j*BW +: BW] = mb[kk][j];
    endtask

    // bub_mode: 0 gap-free, 1 alternating, 2 random. bp_mode: 0 always ready, 1 random, 2 stall row 1 five cycles.
    task automatic run_job(input int k, input int bub_mode, input int bp_mode);
        int beat, cyc, lat, row, stall, tog;
        logic acc, rdy;
        logic [P*ACCW-1:0] hold_d;
        logic [$clog2(M)-1:0] hold_r;
        compute_exp(k);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        start = 1'b1;
        k_len = KW'(k);
        @(negedge clk);
        start = 1'b0;
        k_len = KW'($urandom);
        if (k > 0) begin
            beat = 0; cyc = 0; tog = 0;
            while (beat < k && cyc < 4000) begin
                case (bub_mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (tog % 2) == 0;
                    default: in_valid = $urandom_range(99) >= 40;
                endcase
                tog++;
                if (in_valid) drive_beat(beat);
                else begin
                    a_col = (M*BW)'($urandom);
                    b_row = (P*BW)'($urandom);
                end
                acc = in_valid && in_ready;
                @(negedge clk);
                cyc++;
                if (acc) beat++;
            end
            in_valid = 1'b0;
            chk("beats_accepted", 64'(beat), 64'(k));
            chk("in_ready_flush", 64'(in_ready), 64'(0));
            lat = 1;
            while (!out_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", 64'(lat), 64'(M+P));
        end else begin
            chk("k0_out_valid", 64'(out_valid), 64'(1));
            chk("k0_in_ready", 64'(in_ready), 64'(0));
        end
        row = 0; cyc = 0; stall = 0;
        hold_d = '0; hold_r = '0;
        while (row < M && cyc < 300) begin
            case (bp_mode)
                0:       rdy = 1'b1;
                1:       rdy = $urandom_range(99) < 70;
                default: rdy = !(row == 1 && stall < 5);
            endcase
            out_ready = rdy;
            if (rdy) begin
                chk("out_valid", 64'(out_valid), 64'(1));
                chk("out_row", 64'(out_row), 64'(row));
                for (int j = 0; j < P; j++)
                    chk($sformatf("c[%0d][%0d]", row, j), 64'(out_data[j*ACCW +: ACCW]), 64'(exp_c[row][j]));
                row++;
                stall = 0;
            end else begin
                if (stall > 0) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_data", 64'(out_data[63:0]), 64'(hold_d[63:0]));
                    chk("hold_row", 64'(out_row), 64'(hold_r));
                end
                hold_d = out_data;
                hold_r = out_row;
                stall++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("rows_drained", 64'(row), 64'(M));
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_valid_low", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("done_clear", 64'(done), 64'(0));
        chk("idle_after", 64'(busy), 64'(0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data[63:0]), 64'(0));
        chk({tag, "_out_row"}, 64'(out_row), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;

        // Identity A times B reproduces B.
        for (int i = 0; i < M; i++)
            for (int kk = 0; kk < 4; kk++) ma[i][kk] = (i == kk) ? BW'(1) : BW'(0);
        for (int kk = 0; kk < 4; kk++)
            for (int j = 0; j < P; j++) mb[kk][j] = BW'(kk*4 + j + 1);
        run_job(4, 0, 0);

        // All-255 operands, K=3.
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < M; i++) ma[i][kk] = 8'hFF;
            for (int j = 0; j < P; j++) mb[kk][j] = 8'hFF;
        end
        run_job(3, 0, 0);

        // Same random operands with alternating bubbles, then gap-free.
        fill_random(4);
        run_job(4, 1, 0);
        run_job(4, 0, 0);

        // Row 1 stalled for five cycles.
        fill_random(4);
        run_job(4, 0, 2);

        // Empty inner dimension.
        run_job(0, 0, 0);

        for (int t = 0; t < 6; t++) begin
            int k;
            k = $urandom_range(1, 20);
            fill_random(k);
            run_job(k, 2, 1);
        end

        fill_random(KMAX);
        run_job(KMAX, 0, 1);

        // Reset during FLUSH abandons the job; the next job sees no stale sums.
        fill_random(2);
        @(negedge clk);
        start = 1'b1; k_len = KW'(2);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; drive_beat(0);
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'(1));
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("midreset_hold");
        reset = 1'b1;
        for (int i = 0; i < M; i++) ma[i][0] = BW'(2);
        for (int j = 0; j < P; j++) mb[0][j] = BW'(3);
        run_job(1, 0, 0);

`ifdef SYSTOLIC_SIGNED_EN
        for (int kk = 0; kk < 2; kk++) begin
            for (int i = 0; i < M; i++) ma[i][kk] = 8'hFF;
            for (int j = 0; j < P; j++) mb[kk][j] = BW'(2);
        end
        run_job(2, 0, 0);
        fill_random(8);
        run_job(8, 2, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
